wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file: the consumer at the far end of the MEM/WB pipeline register. It accepts the latched WB control, memory read data, ALU result and destination register from MEM/WB. It selects the write-back value and commits it to a 32 x 32-bit register file. It serves the two ID-stage read ports with same-cycle write-through bypass, and exports the write-back value and enable for EX-stage forwarding.

## Interface
- No parameters; widths fixed at 32 registers x 32 bits.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- wb_en  in  1  stage enable; tie to the MEM/WB enable so a held MEM/WB entry commits exactly once
- mem_wb_wb  in  2  {RegWrite, MemtoReg}: bit 1 RegWrite, bit 0 MemtoReg
- mem_wb_wreg  in  5  destination register number
- mem_wb_rd  in  32  data-memory read data
- mem_wb_alu  in  32  ALU result
- rs_addr  in  5  read port A address (ID stage)
- rt_addr  in  5  read port B address (ID stage)
- rs_data  out  32  read port A data, combinational
- rt_data  out  32  read port B data, combinational
- wb_data  out  32  selected write-back value, combinational, for EX forwarding
- wb_we  out  1  effective write enable this cycle, combinational
- commit_cnt  out  32  registered count of committed register writes

## Operation
- wb_data = mem_wb_wb[0] ? mem_wb_rd : mem_wb_alu.
- wb_we = wb_en & mem_wb_wb[1] & (mem_wb_wreg != 0) & ~rst.
- Register file write:
  - Condition: rising edge with wb_we = 1.
  - Effect: regs[mem_wb_wreg] <= wb_data.
  - Only one write port; all other registers hold.
- Register 0:
  - Reads always return 0.
  - A write to register 0 is discarded and does not increment commit_cnt.
- Read ports (identical behaviour for rs and rt):
  - addr = 0: return 0.
  - Else, if wb_we = 1 and mem_wb_wreg = addr: return wb_data (write-through bypass, so ID sees a value being written in the same cycle).
  - Else: return regs[addr].
- Both read ports may address the same register, including the register being written; both return the same value.
- commit_cnt:
  - Increments by 1 on every rising edge with wb_we = 1.
  - 32-bit, wraps from 0xFFFFFFFF to 0 without a flag.
- wb_en = 0:
  - No write and no count.
  - wb_we = 0, so no bypass either; reads return stored contents.
  - wb_data still reflects its inputs.
- RegWrite = 0 (e.g. store, branch, bubble after a flush of MEM/WB to zero): no state change. A zeroed MEM/WB entry is a no-op.

## Timing
- Reset:
  - rst = 1 at a rising edge clears all 32 registers to 0 and commit_cnt to 0.
  - Reset has priority over any write in the same cycle.
  - While rst = 1: wb_we = 0 and the bypass is inactive, so rs_data and rt_data show stored values (0 after the first reset edge).
  - Reset asserted mid-operation discards the in-flight write.
- Write latency: value committed at the edge ending the WB cycle. It is visible combinationally the same cycle via the bypass, and from stored state the next cycle.
- Read latency: zero cycles (combinational from addresses and stored state).
- commit_cnt updates at the same edge as the register write. It reads the new value from the following cycle.
- No handshake beyond wb_en; the block never stalls the pipeline.

## Test plan
- Reset:
  - Stimulus: preload regs via writes, then rst = 1 for one cycle.
  - Required: all 32 regs read 0 on both ports; commit_cnt = 0.
  - Stimulus: same cycle as reset, wb = 2'b10, wreg = 5, alu = 0x1234.
  - Required: reg 5 stays 0.
- ALU vs memory select:
  - wb = 2'b10, wreg = 8, alu = 0xDEADBEEF, rd = 0x11111111 -> reg 8 = 0xDEADBEEF.
  - wb = 2'b11, wreg = 9 -> reg 9 = 0x11111111.
  - Required: commit_cnt = 2.
- Bypass:
  - Stimulus: wb = 2'b10, wreg = 3, alu = 0xCAFE0001 with rs_addr = rt_addr = 3 in the same cycle.
  - Required: both ports read 0xCAFE0001 before the edge and after it.
  - Stimulus: wb_en = 0 with the same inputs.
  - Required: ports return the old reg 3 value.
- Register 0:
  - Stimulus: wb = 2'b10, wreg = 0, alu = 0xFFFFFFFF.
  - Required: wb_we = 0, rs_data for addr 0 = 0, commit_cnt unchanged.
- Stall / no double commit:
  - Stimulus: hold MEM/WB inputs constant (wreg = 4, alu = 7) for 3 cycles with wb_en = 1, 0, 0.
  - Required: commit_cnt += 1 only; reg 4 = 7.
- Counter wrap:
  - Stimulus: force the count to 0xFFFFFFFF via 2^32 - 1 writes, or a bench backdoor, then perform one valid write.
  - Required: commit_cnt = 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage and 32 x 32-bit architectural register file.
// Selects the write-back value, commits it, and serves two combinational
// ID-stage read ports with same-cycle write-through bypass.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [1:0]  mem_wb_wb,
  input  logic [4:0]  mem_wb_wreg,
  input  logic [31:0] mem_wb_rd,
  input  logic [31:0] mem_wb_alu,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic [31:0] commit_cnt
);

  logic [31:0] regs [32];

  // Write-back value selection and effective write enable. Register 0 is
  // masked here so it never commits, counts or bypasses.
  always_comb begin
    wb_data = mem_wb_wb[0] ? mem_wb_rd : mem_wb_alu;
    wb_we   = wb_en & mem_wb_wb[1] & (mem_wb_wreg != 5'd0) & ~rst;
  end

  // Register file storage; reset clears every entry and wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_we) begin
      regs[mem_wb_wreg] <= wb_data;
    end
  end

  // Commit counter; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt <= 32'd0;
    end else if (wb_we) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

  // Read port A with zero-register and write-through bypass.
  always_comb begin
    if (rs_addr == 5'd0) begin
      rs_data = 32'd0;
    end else if (wb_we && (mem_wb_wreg == rs_addr)) begin
      rs_data = wb_data;
    end else begin
      rs_data = regs[rs_addr];
    end
  end

  // Read port B, identical to port A.
  always_comb begin
    if (rt_addr == 5'd0) begin
      rt_data = 32'd0;
    end else if (wb_we && (mem_wb_wreg == rt_addr)) begin
      rt_data = wb_data;
    end else begin
      rt_data = regs[rt_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [1:0]  mem_wb_wb;
  logic [4:0]  mem_wb_wreg;
  logic [31:0] mem_wb_rd;
  logic [31:0] mem_wb_alu;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] commit_cnt;

  int n_vec;
  int n_bad;

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .wb_en       (wb_en),
    .mem_wb_wb   (mem_wb_wb),
    .mem_wb_wreg (mem_wb_wreg),
    .mem_wb_rd   (mem_wb_rd),
    .mem_wb_alu  (mem_wb_alu),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .commit_cnt  (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b1;
    mem_wb_wb = 2'b00;
    mem_wb_wreg = 5'd0;
    mem_wb_rd = 32'd0;
    mem_wb_alu = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd5; mem_wb_alu = 32'h0000_0055;
    tick();
    mem_wb_wreg = 5'd6; mem_wb_alu = 32'h0000_0066;
    tick();
    rs_addr = 5'd5; rt_addr = 5'd6; idle(); #1;
    n_vec++;
    if (rs_data !== 32'h55 || rt_data !== 32'h66) begin
      n_bad++;
      $display("FAIL preload rs=%h rt=%h want 55/66", rs_data, rt_data);
    end
    rst = 1'b1;
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd5; mem_wb_alu = 32'h0000_1234;
    rs_addr = 5'd5; #1;
    n_vec++;
    if (wb_we !== 1'b0 || rs_data !== 32'h55) begin
      n_bad++;
      $display("FAIL rst_no_bypass we=%b rs=%h want 0/55", wb_we, rs_data);
    end
    tick();
    rst = 1'b0;
    idle(); #1;
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a); #1;
      n_vec++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_clear a=%0d rs=%h rt=%h want 0", a, rs_data, rt_data);
      end
    end
    n_vec++;
    if (commit_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %h want 0", commit_cnt);
    end
  endtask

  task automatic test_select();
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd8;
    mem_wb_alu = 32'hDEAD_BEEF; mem_wb_rd = 32'h1111_1111; #1;
    n_vec++;
    if (wb_data !== 32'hDEAD_BEEF || wb_we !== 1'b1) begin
      n_bad++;
      $display("FAIL sel_alu wb_data=%h we=%b want deadbeef/1", wb_data, wb_we);
    end
    tick();
    mem_wb_wb = 2'b11; mem_wb_wreg = 5'd9; #1;
    n_vec++;
    if (wb_data !== 32'h1111_1111) begin
      n_bad++;
      $display("FAIL sel_mem wb_data=%h want 11111111", wb_data);
    end
    tick();
    idle();
    rs_addr = 5'd8; rt_addr = 5'd9; #1;
    n_vec++;
    if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'h1111_1111) begin
      n_bad++;
      $display("FAIL sel_stored rs=%h rt=%h want deadbeef/11111111", rs_data, rt_data);
    end
    n_vec++;
    if (commit_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL sel_cnt got %0d want 2", commit_cnt);
    end
  endtask

  task automatic test_bypass();
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd3; mem_wb_alu = 32'hCAFE_0001;
    rs_addr = 5'd3; rt_addr = 5'd3; #1;
    n_vec++;
    if (rs_data !== 32'hCAFE_0001 || rt_data !== 32'hCAFE_0001) begin
      n_bad++;
      $display("FAIL bypass_pre rs=%h rt=%h want cafe0001", rs_data, rt_data);
    end
    tick();
    idle(); #1;
    n_vec++;
    if (rs_data !== 32'hCAFE_0001 || rt_data !== 32'hCAFE_0001) begin
      n_bad++;
      $display("FAIL bypass_post rs=%h rt=%h want cafe0001", rs_data, rt_data);
    end
    wb_en = 1'b0;
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd3; mem_wb_alu = 32'hBBBB_0000; #1;
    n_vec++;
    if (rs_data !== 32'hCAFE_0001 || rt_data !== 32'hCAFE_0001 || wb_we !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_disabled rs=%h rt=%h we=%b want cafe0001/0", rs_data, rt_data, wb_we);
    end
    n_vec++;
    if (wb_data !== 32'hBBBB_0000) begin
      n_bad++;
      $display("FAIL disabled_wb_data got %h want bbbb0000", wb_data);
    end
    tick();
    n_vec++;
    if (rs_data !== 32'hCAFE_0001 || commit_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL disabled_hold rs=%h cnt=%0d want cafe0001/3", rs_data, commit_cnt);
    end
    idle();
  endtask

  task automatic test_distinct_ports();
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd9; mem_wb_alu = 32'h0BAD_F00D;
    rs_addr = 5'd8; rt_addr = 5'd3; #1;
    n_vec++;
    if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hCAFE_0001) begin
      n_bad++;
      $display("FAIL no_false_bypass rs=%h rt=%h want deadbeef/cafe0001", rs_data, rt_data);
    end
    rt_addr = 5'd9; #1;
    n_vec++;
    if (rt_data !== 32'h0BAD_F00D || rs_data !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL port_b_bypass rs=%h rt=%h want deadbeef/0badf00d", rs_data, rt_data);
    end
    tick();
    idle(); #1;
    n_vec++;
    if (rt_data !== 32'h0BAD_F00D || rs_data !== 32'hDEAD_BEEF || commit_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL single_port_write rs=%h rt=%h cnt=%0d want deadbeef/0badf00d/4", rs_data, rt_data, commit_cnt);
    end
  endtask

  task automatic test_reg0();
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd0; mem_wb_alu = 32'hFFFF_FFFF;
    rs_addr = 5'd0; rt_addr = 5'd0; #1;
    n_vec++;
    if (wb_we !== 1'b0 || rs_data !== 32'd0 || rt_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reg0_pre we=%b rs=%h rt=%h want 0/0/0", wb_we, rs_data, rt_data);
    end
    tick();
    idle(); #1;
    n_vec++;
    if (rs_data !== 32'd0 || commit_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL reg0_post rs=%h cnt=%0d want 0/4", rs_data, commit_cnt);
    end
  endtask

  task automatic test_stall();
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd4; mem_wb_alu = 32'd7;
    wb_en = 1'b1;
    tick();
    wb_en = 1'b0;
    tick();
    tick();
    idle();
    rs_addr = 5'd4; #1;
    n_vec++;
    if (commit_cnt !== 32'd5 || rs_data !== 32'd7) begin
      n_bad++;
      $display("FAIL stall cnt=%0d r4=%h want 5/7", commit_cnt, rs_data);
    end
    mem_wb_wb = 2'b01; mem_wb_wreg = 5'd4; mem_wb_rd = 32'h99;
    tick();
    idle(); #1;
    n_vec++;
    if (commit_cnt !== 32'd5 || rs_data !== 32'd7) begin
      n_bad++;
      $display("FAIL no_regwrite cnt=%0d r4=%h want 5/7", commit_cnt, rs_data);
    end
  endtask

  task automatic test_wrap();
    force dut.commit_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.commit_cnt;
    #1;
    n_vec++;
    if (commit_cnt !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL wrap_preset got %h want ffffffff", commit_cnt);
    end
    mem_wb_wb = 2'b10; mem_wb_wreg = 5'd10; mem_wb_alu = 32'h0000_00AA;
    tick();
    idle();
    rs_addr = 5'd10; #1;
    n_vec++;
    if (commit_cnt !== 32'd0 || rs_data !== 32'hAA) begin
      n_bad++;
      $display("FAIL wrap cnt=%h r10=%h want 0/aa", commit_cnt, rs_data);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    idle();
    tick();
    tick();
    test_reset();
    test_select();
    test_bypass();
    test_distinct_ports();
    test_reg0();
    test_stall();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
